// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide sequencer: op codes issued
// by the decoder, FSM state encoding and the default datapath width.
// Optional feature macro used by the sequencer: MULDIV_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the unsigned multiply/divide datapath.
// The working value is a 2*WIDTH pair {ph, pl}:
//   multiply : ph = partial product high, pl = multiplier bits still to be
//              consumed (LSB first) with product bits shifting in from the top.
//   divide   : ph = partial remainder, pl = dividend bits still to be
//              consumed (MSB first) with quotient bits shifting in at the LSB.
// Ports:
//   i_is_div   1      select restoring-divide step (else shift-add multiply)
//   i_ph/i_pl  WIDTH  current working pair
//   i_b        WIDTH  multiplicand magnitude or divisor magnitude
//   o_ph/o_pl  WIDTH  working pair after one iteration
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_ph,
    input  logic [WIDTH-1:0] i_pl,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_ph,
    output logic [WIDTH-1:0] o_pl
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_ph} + (i_pl[0] ? {1'b0, i_b} : '0);
        w_shifted = {i_ph, i_pl[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_b};
        if (i_is_div) begin
            // remainder < divisor keeps w_shifted < 2*divisor, so bit WIDTH of
            // the difference is a clean borrow flag
            if (w_diff[WIDTH]) begin
                o_ph = w_shifted[WIDTH-1:0];
                o_pl = {i_pl[WIDTH-2:0], 1'b0};
            end else begin
                o_ph = w_diff[WIDTH-1:0];
                o_pl = {i_pl[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_ph = w_sum[WIDTH:1];
            o_pl = {w_sum[0], i_pl[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle controller for the HI/LO multiply/divide resource. Runs a radix-2
// shift-add multiply or restoring divide over WIDTH iterations, applies signs,
// owns HI/LO and raises busy to stall the core while an operation is in flight.
// Optional feature: define MULDIV_EARLY_EXIT_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (multiply only).
// Ports:
//   clk       core clock, rising edge
//   reset     asynchronous active-low reset
//   start     issue pulse from the decoder
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_data   multiplicand / dividend / MTHI-MTLO source
//   rt_data   multiplier / divisor
//   flush     abort back to IDLE, HI/LO untouched
//   busy      stall request
//   done      one-cycle completion pulse
//   div_zero  one-cycle pulse for a divide by zero (not issued)
//   hi, lo    HI/LO registers
// -----------------------------------------------------------------------------
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO and divide-by-zero handled here
// S_CALC | one multiply/divide iteration per cycle
// S_FIX  | sign correction, HI/LO written on exit
// S_DONE | done pulse, result visible
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_ph, r_pl, r_b;
    logic             r_is_div, r_sa, r_sb;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_busy, r_done, r_div_zero;
`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] r_mrem;
`endif

    logic             w_is_div_op, w_signed, w_zero_div, w_issue, w_last;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH-1:0] w_step_ph, w_step_pl;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed    = (op == OP_MULT) || (op == OP_DIV);
    assign w_zero_div  = w_is_div_op && (rt_data == '0);
    assign w_issue     = (r_state == S_IDLE) && start && !flush
                         && (op <= OP_DIVU) && !w_zero_div;
    assign w_a_neg     = w_signed && rs_data[WIDTH-1];
    assign w_b_neg     = w_signed && rt_data[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -rs_data : rs_data;
    assign w_b_mag     = w_b_neg ? -rt_data : rt_data;

`ifdef MULDIV_EARLY_EXIT_EN
    // r_mrem still holds the bit consumed this cycle, so look above it
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1))
                    || (!r_is_div && (r_mrem[WIDTH-1:1] == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_ph     (r_ph),
        .i_pl     (r_pl),
        .i_b      (r_b),
        .o_ph     (w_step_ph),
        .o_pl     (w_step_pl)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_issue) w_next = S_CALC;
                S_CALC:  if (w_last)  w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_prod = {r_ph, r_pl};
`ifdef MULDIV_EARLY_EXIT_EN
        // after an early exit the product sits (WIDTH-1-cnt) bits too high
        w_prod = w_prod >> (CNT_W'(WIDTH - 1) - r_cnt);
`endif
        if (r_sa ^ r_sb) w_prod = -w_prod;
        w_quo = (r_sa ^ r_sb) ? -r_pl : r_pl;
        w_rem = r_sa ? -r_ph : r_ph;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_ph       <= '0;
            r_pl       <= '0;
            r_b        <= '0;
            r_is_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            r_mrem     <= '0;
`endif
        end else begin
            r_busy     <= (w_next == S_CALC) || (w_next == S_FIX);
            r_done     <= (w_next == S_DONE);
            r_div_zero <= (r_state == S_IDLE) && start && !flush && w_zero_div;

            if ((r_state == S_IDLE) && start && !flush) begin
                if (op == OP_MTHI) r_hi <= rs_data;
                if (op == OP_MTLO) r_lo <= rs_data;
            end

            if (w_issue) begin
                r_cnt    <= '0;
                r_ph     <= '0;
                r_is_div <= w_is_div_op;
                r_sa     <= w_a_neg;
                r_sb     <= w_b_neg;
                // multiply consumes the multiplier from pl; divide the dividend
                r_pl     <= w_is_div_op ? w_a_mag : w_b_mag;
                r_b      <= w_is_div_op ? w_b_mag : w_a_mag;
`ifdef MULDIV_EARLY_EXIT_EN
                r_mrem   <= w_b_mag;
`endif
            end else if ((r_state == S_CALC) && !flush) begin
                r_ph <= w_step_ph;
                r_pl <= w_step_pl;
                // counter holds on exit so FIX knows how many steps ran
                if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
`ifdef MULDIV_EARLY_EXIT_EN
                r_mrem <= r_mrem >> 1;
`endif
            end else if ((r_state == S_FIX) && !flush) begin
                if (r_is_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the CPU's HI/LO multiply/divide resource. It sequences a radix-2 shift-add multiplier and restoring divider over 32 iterations, owns the HI/LO registers, and drives a busy stall to the single-cycle core while an operation is in flight. It sits beside the ALU; the decoder issues a start pulse for MULT/MULTU/DIV/DIVU/MTHI/MTLO.

Parameters:
WIDTH, 32, operand/HI/LO width
CNT_W, 5, iteration counter width (2^CNT_W == WIDTH)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  issue pulse, sampled on rising clk
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
rs_data  input  WIDTH  multiplicand/dividend, or MTHI/MTLO source
rt_data  input  WIDTH  multiplier/divisor
flush  input  1  abort from exception/eret logic
busy  output  1  stall request to PC/controller
done  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse: divide with rt_data==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0, lo=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start + op MULT..DIVU, divisor nonzero: latch magnitudes and signs (signed ops take |x|); counter=0; -> CALC. busy=1 from the next cycle.
- IDLE + start + DIV/DIVU with rt_data==0: stay IDLE; div_zero=1 for one cycle; hi/lo unchanged; busy stays 0.
- IDLE + start + MTHI/MTLO: hi or lo <= rs_data on that edge; stay IDLE; no busy, no done.
- IDLE + start + op 6-7: ignored.
- CALC: one iteration per cycle. Multiply: shift-add on a 2*WIDTH accumulator. Divide: restoring step, one quotient bit per cycle. After counter reaches WIDTH-1 -> FIX.
- FIX (1 cycle): apply sign. Product negated if sa^sb. Quotient negated if sa^sb; remainder takes the sign of the dividend. DIV 0x80000000 / -1 gives lo=0x80000000, hi=0 (wrap, no trap). -> DONE; hi/lo are written on this edge.
- DONE (1 cycle): done=1, busy=0, hi/lo valid. -> IDLE.
- Latency: start edge E0; busy=1 for cycles E0..E33 (32 CALC + 1 FIX); done=1 in the cycle after E33; new start accepted from E34.
- A start while in CALC/FIX/DONE is ignored. The core holds start low while busy; the bench checks this.
- flush in any state: -> IDLE on the next edge; busy/done drop to 0; hi/lo keep prior values. flush and start in the same IDLE cycle: flush wins, nothing issued.
- An asynchronous reset mid-operation clears everything, including hi/lo.
- Outputs are registered; hi/lo never show partial results.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: in CALC for multiply ops, when the remaining unshifted multiplier bits are all zero, the controller advances to FIX at once; the accumulator is shifted into final alignment in FIX. Latency = (index of the multiplier's highest set bit + 1) CALC cycles + FIX + DONE. A multiplier of 0 takes 1 CALC cycle. Divide latency is unchanged.
- Undefined: fixed 32-cycle CALC for all ops; the early-exit logic is absent.

Decomposition:
- Package muldiv_pkg: op code constants (OP_MULT..OP_MTLO), state encoding enum, WIDTH default.
- Sub-module muldiv_step: combinational single-iteration datapath (add/shift, trial subtract) instanced once; muldiv_sequencer keeps the FSM, counter, sign latches and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, done pulse at E34 cycle, hi=0xFFFFFFFE lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. With MULDIV_EARLY_EXIT_EN: 3 CALC cycles.
- DIV -7 / 2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=0x0000000E hi=0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0x00000000. DIVU 5 / 0 -> div_zero pulse, no busy, hi/lo unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge, busy stays 0.
- MULTU started, flush at CALC cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. Repeat with reset=0 mid-CALC -> all outputs 0 immediately.
